// File: rtl/dma_pkg.sv
// Shared constants and the host-port state type for the DMA memory target.
package dma_pkg;
  localparam int DATA_W     = 32;
  localparam int WORD_SHIFT = 2;

  typedef enum logic {
    H_IDLE,
    H_RESP
  } host_state_t;
endpackage

// File: rtl/dma_sram_core.sv
// Single-port synchronous RAM with registered read data.
// The read returns the word as it was before a same-cycle write.
module dma_sram_core #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/dma_mem_target.sv
// Memory-side responder for the DMA master bus, with a lower-priority host port.
// state  | meaning
// H_IDLE | host port free; accepts a request when no DMA strobe is present
// H_RESP | host read data on host_rdata, host_rvalid high
module dma_mem_target
  import dma_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = dma_pkg::DATA_W,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write,
  output logic [DATA_W-1:0] mem_read,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              err_misalign,
  output logic              err_range,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);
  host_state_t state, state_next;

  logic              dma_strobe;
  logic [AW-1:0]     dma_idx;
  logic              dma_oob;
  logic              dma_mis;
  logic              host_accept;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              dma_rd_q;
  logic              dma_oob_q;
  logic [DATA_W-1:0] mem_read_hold;
  logic [DATA_W-1:0] host_rdata_hold;

  assign dma_strobe = mem_r_en | mem_w_en;
  assign dma_idx    = mem_addr[WORD_SHIFT +: AW];
  assign dma_oob    = (mem_addr >> WORD_SHIFT) >= ADDR_W'(DEPTH);
  assign dma_mis    = |mem_addr[WORD_SHIFT-1:0];

  always_comb begin
    state_next  = state;
    host_accept = 1'b0;
    host_rvalid = 1'b0;
    case (state)
      H_IDLE: begin
        if (host_req && !dma_strobe && !rst) begin
          host_accept = 1'b1;
          if (!host_we) state_next = H_RESP;
        end
      end
      H_RESP: begin
        host_rvalid = 1'b1;
        state_next  = H_IDLE;
      end
      default: state_next = H_IDLE;
    endcase
  end

  assign host_ready = host_accept;

  // DMA owns the single RAM port whenever it strobes; the host only gets idle cycles.
  assign ram_en    = dma_strobe | host_accept;
  assign ram_we    = dma_strobe ? (mem_w_en & ~dma_oob) : host_we;
  assign ram_addr  = dma_strobe ? dma_idx : host_addr;
  assign ram_wdata = dma_strobe ? mem_write : host_wdata;

  dma_sram_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM read data is shared, so each side keeps its own copy to hold between reads.
  assign mem_read   = dma_rd_q ? (dma_oob_q ? '0 : ram_rdata) : mem_read_hold;
  assign host_rdata = (state == H_RESP) ? ram_rdata : host_rdata_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= H_IDLE;
      dma_rd_q        <= 1'b0;
      dma_oob_q       <= 1'b0;
      mem_read_hold   <= '0;
      host_rdata_hold <= '0;
      err_misalign    <= 1'b0;
      err_range       <= 1'b0;
      rd_count        <= '0;
      wr_count        <= '0;
    end else begin
      state     <= state_next;
      dma_rd_q  <= mem_r_en;
      dma_oob_q <= dma_oob;
      if (dma_rd_q) mem_read_hold <= mem_read;
      if (state == H_RESP) host_rdata_hold <= host_rdata;
      err_misalign <= (dma_strobe & dma_mis) | (err_misalign & ~err_clr);
      err_range    <= (dma_strobe & dma_oob) | (err_range & ~err_clr);
      rd_count     <= (err_clr ? '0 : rd_count) + CNT_W'(mem_r_en);
      wr_count     <= (err_clr ? '0 : wr_count) + CNT_W'(mem_w_en);
    end
  end
endmodule

// File: tb/tb_dma_mem_target.sv
// Self-checking bench: randomized DMA/host traffic against an array-based memory model.
module tb_dma_mem_target;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_write, mem_read;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_ready, host_rvalid;
  logic        err_misalign, err_range, err_clr;
  logic [15:0] rd_count, wr_count;

  logic        r4;
  logic [31:0] mem_read4, host_rdata4;
  logic        host_ready4, host_rvalid4, err_mis4, err_rng4;
  logic [3:0]  rd_count4, wr_count4;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_read, m_hrdata;
  logic [15:0] m_rd, m_wr;
  logic        m_mis, m_rng;

  always #5 clk = ~clk;

  dma_mem_target dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_read(mem_read), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .err_misalign(err_misalign),
    .err_range(err_range), .err_clr(err_clr), .rd_count(rd_count), .wr_count(wr_count)
  );

  dma_mem_target #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_r_en(r4), .mem_w_en(1'b0), .mem_addr(32'h0),
    .mem_write(32'h0), .mem_read(mem_read4), .host_req(1'b0), .host_we(1'b0),
    .host_addr(8'h0), .host_wdata(32'h0), .host_ready(host_ready4),
    .host_rvalid(host_rvalid4), .host_rdata(host_rdata4), .err_misalign(err_mis4),
    .err_range(err_rng4), .err_clr(1'b0), .rd_count(rd_count4), .wr_count(wr_count4)
  );

  // One DMA cycle; the model applies the access rules after the edge.
  task automatic dma_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic clr, output logic hr);
    logic [29:0] idx;
    logic        oob;
    mem_r_en = r; mem_w_en = w; mem_addr = a; mem_write = d; err_clr = clr;
    #1 hr = host_ready;
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; err_clr = 1'b0;
    idx = a[31:2];
    oob = (idx >= 30'd256);
    if (r) m_read = oob ? 32'h0 : m_mem[idx[7:0]];
    if (w && !oob) m_mem[idx[7:0]] = d;
    m_rd = (clr ? 16'd0 : m_rd) + 16'(r);
    m_wr = (clr ? 16'd0 : m_wr) + 16'(w);
    if (clr) begin m_mis = 1'b0; m_rng = 1'b0; end
    if ((r || w) && a[1:0] != 2'b00) m_mis = 1'b1;
    if ((r || w) && oob) m_rng = 1'b1;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d, output logic rdy);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1 rdy = host_ready;
    @(negedge clk);
    host_req = 1'b0;
    if (rdy) m_mem[a] = d;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic rdy, output logic vld,
                         output logic [31:0] data);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    #1 rdy = host_ready;
    @(negedge clk);
    host_req = 1'b0;
    vld  = host_rvalid;
    data = host_rdata;
    if (rdy) m_hrdata = m_mem[a];
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_read = '0; m_hrdata = '0; m_rd = '0; m_wr = '0; m_mis = 1'b0; m_rng = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_write = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; err_clr = 1'b0; r4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++;
    if ({mem_read, host_rdata, host_ready, host_rvalid, err_misalign, err_range, rd_count, wr_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%h hrd=%h rdy=%b vld=%b em=%b er=%b rc=%0d wc=%0d, expected all 0",
               mem_read, host_rdata, host_ready, host_rvalid, err_misalign, err_range, rd_count, wr_count);
    end
    tests++;
    if ({rd_count4, wr_count4, err_mis4, err_rng4} !== '0) begin
      fails++;
      $display("FAIL reset_cnt4: got rc=%0d wc=%0d, expected 0", rd_count4, wr_count4);
    end
  endtask

  task automatic test_preload();
    logic rdy;
    int   bad = 0;
    for (int i = 0; i < 256; i++) begin
      host_wr(8'(i), $urandom, rdy);
      if (rdy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL preload_ready: got %0d refused writes, expected 0", bad); end
  endtask

  task automatic test_copy();
    logic        rdy, vld, hr;
    logic [31:0] v, data;
    for (int i = 0; i < 4; i++) host_wr(8'(i), 32'hA0A0_0000 + 32'(i), rdy);
    dma_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, hr);
    for (int i = 0; i < 4; i++) begin
      dma_op(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, hr);
      v = mem_read;
      tests++;
      if (v !== 32'hA0A0_0000 + 32'(i)) begin
        fails++; $display("FAIL copy_src%0d: got %h expected %h", i, v, 32'hA0A0_0000 + 32'(i));
      end
      dma_op(1'b0, 1'b1, 32'h40 + 32'(i * 4), v, 1'b0, hr);
    end
    for (int i = 0; i < 4; i++) begin
      host_rd(8'(16 + i), rdy, vld, data);
      tests++;
      if ({rdy, vld, data} !== {2'b11, 32'hA0A0_0000 + 32'(i)}) begin
        fails++; $display("FAIL copy_dst%0d: got rdy=%b vld=%b data=%h expected 1 1 %h",
                          i, rdy, vld, data, 32'hA0A0_0000 + 32'(i));
      end
    end
    tests++;
    if (rd_count !== 16'd4 || wr_count !== 16'd4) begin
      fails++; $display("FAIL copy_counts: got rd=%0d wr=%0d expected 4 4", rd_count, wr_count);
    end
  endtask

  task automatic test_rmw();
    logic        rdy, vld, hr;
    logic [31:0] data;
    host_wr(8'd2, 32'h11, rdy);
    dma_op(1'b1, 1'b1, 32'h08, 32'h22, 1'b0, hr);
    tests++;
    if (mem_read !== 32'h11) begin fails++; $display("FAIL rmw_old: got %h expected 00000011", mem_read); end
    host_rd(8'd2, rdy, vld, data);
    tests++;
    if (data !== 32'h22) begin fails++; $display("FAIL rmw_new: got %h expected 00000022", data); end
  endtask

  task automatic test_host_wait();
    logic hr;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
    for (int k = 0; k < 5; k++) begin
      dma_op(1'b1, 1'b0, 32'(k * 4), 32'h0, 1'b0, hr);
      tests++;
      if (hr !== 1'b0 || mem_read !== m_read) begin
        fails++; $display("FAIL wait_cyc%0d: got ready=%b rd=%h expected 0 %h", k, hr, mem_read, m_read);
      end
    end
    #1;
    tests++;
    if (host_ready !== 1'b1) begin fails++; $display("FAIL wait_grant: got ready=%b expected 1", host_ready); end
    @(negedge clk);
    host_req = 1'b0;
    m_hrdata = m_mem[5];
    tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== m_hrdata) begin
      fails++; $display("FAIL wait_rvalid: got vld=%b data=%h expected 1 %h", host_rvalid, host_rdata, m_hrdata);
    end
    @(negedge clk);
    tests++;
    if (host_rvalid !== 1'b0) begin fails++; $display("FAIL wait_pulse: got vld=%b expected 0", host_rvalid); end
  endtask

  task automatic test_errors();
    logic        rdy, vld, hr;
    logic [31:0] data;
    dma_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, hr);
    dma_op(1'b0, 1'b1, 32'h0000_0402, 32'hDEAD_BEEF, 1'b0, hr);
    tests++;
    if ({err_misalign, err_range, wr_count} !== {2'b11, 16'd1}) begin
      fails++; $display("FAIL err_flags: got mis=%b rng=%b wc=%0d expected 1 1 1", err_misalign, err_range, wr_count);
    end
    host_rd(8'd0, rdy, vld, data);
    tests++;
    if (data !== m_mem[0]) begin fails++; $display("FAIL err_nowrite: got %h expected %h", data, m_mem[0]); end
    dma_op(1'b1, 1'b0, 32'h0000_0402, 32'h0, 1'b0, hr);
    tests++;
    if (mem_read !== 32'h0) begin fails++; $display("FAIL err_oob_read: got %h expected 0", mem_read); end
    dma_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, hr);
    tests++;
    if ({err_misalign, err_range, rd_count, wr_count} !== '0) begin
      fails++; $display("FAIL err_clr: got mis=%b rng=%b rc=%0d wc=%0d expected all 0",
                        err_misalign, err_range, rd_count, wr_count);
    end
  endtask

  task automatic test_clr_collision();
    logic hr;
    dma_op(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, hr);
    dma_op(1'b1, 1'b1, 32'h0000_0007, 32'h1234_5678, 1'b1, hr);
    tests++;
    if ({rd_count, wr_count, err_misalign, err_range} !== {16'd1, 16'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL clr_collision: got rc=%0d wc=%0d mis=%b rng=%b expected 1 1 1 0",
                        rd_count, wr_count, err_misalign, err_range);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    host_req = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_addr = 8'(40 + i); host_wdata = $urandom;
      #1 if (host_ready !== 1'b1) bad++;
      @(negedge clk);
      m_mem[40 + i] = host_wdata;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL b2b_writes: got %0d stalled cycles expected 0", bad); end
    host_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_addr = 8'(40 + i);
      #1;
      tests++;
      if (host_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept%0d: got ready=%b expected 1", i, host_ready); end
      @(negedge clk);
      #1;
      tests++;
      if ({host_ready, host_rvalid, host_rdata} !== {2'b01, m_mem[40 + i]}) begin
        fails++; $display("FAIL b2b_resp%0d: got rdy=%b vld=%b data=%h expected 0 1 %h",
                          i, host_ready, host_rvalid, host_rdata, m_mem[40 + i]);
      end
      @(negedge clk);
    end
    host_req = 1'b0;
    m_hrdata = m_mem[43];
  endtask

  task automatic test_random();
    logic        r, w, clr, hr, rdy, vld;
    logic [31:0] a, data, exp;
    logic [7:0]  ha;
    int          op, idx, lo;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5);
      if (op <= 3) begin
        r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        idx = $urandom_range(0, 255);
        if ($urandom_range(0, 7) == 0) idx = $urandom_range(256, 1023);
        lo  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        a   = 32'(idx * 4 + lo);
        clr = ($urandom_range(0, 15) == 0);
        dma_op(r, w, a, $urandom, clr, hr);
        tests++;
        if ({mem_read, err_misalign, err_range, rd_count, wr_count} !== {m_read, m_mis, m_rng, m_rd, m_wr}) begin
          fails++; $display("FAIL rand_dma%0d: got rd=%h mis=%b rng=%b rc=%0d wc=%0d expected %h %b %b %0d %0d",
                            n, mem_read, err_misalign, err_range, rd_count, wr_count,
                            m_read, m_mis, m_rng, m_rd, m_wr);
        end
      end else if (op == 4) begin
        host_wr(8'($urandom_range(0, 255)), $urandom, rdy);
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("FAIL rand_hwr%0d: got ready=%b expected 1", n, rdy); end
      end else begin
        ha  = 8'($urandom_range(0, 255));
        exp = m_mem[ha];
        host_rd(ha, rdy, vld, data);
        tests++;
        if ({rdy, vld, data} !== {2'b11, exp}) begin
          fails++; $display("FAIL rand_hrd%0d: got rdy=%b vld=%b data=%h expected 1 1 %h", n, rdy, vld, data, exp);
        end
      end
    end
    tests++;
    if (host_rdata !== m_hrdata) begin
      fails++; $display("FAIL rand_hold: got host_rdata=%h expected %h", host_rdata, m_hrdata);
    end
  endtask

  task automatic test_reset_resp();
    logic        rdy, vld, hr;
    logic [31:0] data;
    dma_op(1'b1, 1'b1, 32'h0000_0045, 32'hCAFE_0001, 1'b0, hr);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd16;
    @(negedge clk);
    host_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++;
    if ({mem_read, host_rdata, host_ready, host_rvalid, err_misalign, err_range, rd_count, wr_count} !== '0) begin
      fails++; $display("FAIL rst_in_resp: got rd=%h hrd=%h rdy=%b vld=%b em=%b er=%b rc=%0d wc=%0d, expected all 0",
                        mem_read, host_rdata, host_ready, host_rvalid, err_misalign, err_range, rd_count, wr_count);
    end
    host_rd(8'd17, rdy, vld, data);
    tests++;
    if (data !== m_mem[17]) begin fails++; $display("FAIL rst_ram_kept: got %h expected %h", data, m_mem[17]); end
  endtask

  task automatic test_cnt_wrap();
    r4 = 1'b1;
    repeat (17) @(negedge clk);
    r4 = 1'b0;
    tests++;
    if (rd_count4 !== 4'd1 || wr_count4 !== 4'd0) begin
      fails++; $display("FAIL cnt_wrap: got rd=%0d wr=%0d expected 1 0", rd_count4, wr_count4);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_copy();
    test_rmw();
    test_host_wait();
    test_errors();
    test_clr_collision();
    test_back_to_back();
    test_random();
    test_reset_resp();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
